// File: rtl/irq_seq_pkg.sv
`default_nettype none
// ==========================================================================
// irq_seq_pkg : shared types and constants for the IRQ vector sequencer
// Revision    : 1.0
// ==========================================================================
package irq_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_HI    = 2'd1,
        ST_IN_SERVICE = 2'd2
    } state_t;

    localparam logic CSR_ID   = 1'b0;
    localparam logic CSR_CTRL = 1'b1;

    localparam int STAT_ENABLE     = 0;
    localparam int STAT_IN_SERVICE = 1;
    localparam int STAT_PENDING    = 2;
    localparam int STAT_SPURIOUS   = 3;
    localparam int STAT_ABORT      = 4;
    localparam int STAT_EOI_ERR    = 5;
    localparam int STAT_NEST       = 6;

    localparam logic [15:0] VEC_LO_ADDR = 16'hFFFE;
    localparam logic [15:0] VEC_HI_ADDR = 16'hFFFF;

    // Each handler stub is 4 bytes; the sum wraps at 16 bits.
    function automatic logic [15:0] stub_target(input logic [15:0] base, input logic [15:0] id);
        return base + (id << 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_seq_csr.sv
`default_nettype none
// ==========================================================================
// irq_seq_csr : enable bit, sticky W1C status flags and CSR read mux
// Revision    : 1.0
// ==========================================================================
module irq_seq_csr
    import irq_seq_pkg::*;
#(
    parameter int ID_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cs,
    input  logic                addr,
    input  logic                rwb,
    input  logic [7:0]          wdata,
    input  logic                spur_set,
    input  logic                abort_set,
    input  logic                eoi_err_set,
    input  logic                nest_set,
    input  logic                irq_pending,
    input  logic                in_service,
    input  logic [ID_WIDTH-1:0] svc_id,
    output logic                enable,
    output logic [7:0]          rdata
);

    logic spurious;
    logic abort;
    logic eoi_err;
    logic nest;
    logic ctrl_wr;
    logic unused_wdata;

    assign ctrl_wr      = cs & ~rwb & (addr == CSR_CTRL);
    assign unused_wdata = ^{wdata[7], wdata[2:1]};

    // A hardware set in the same cycle as a W1C clear keeps the flag set.
    always_ff @(negedge clk) begin
        if (reset) begin
            enable   <= 1'b0;
            spurious <= 1'b0;
            abort    <= 1'b0;
            eoi_err  <= 1'b0;
            nest     <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                enable <= wdata[STAT_ENABLE];
            end
            spurious <= spur_set    | (spurious & ~(ctrl_wr & wdata[STAT_SPURIOUS]));
            abort    <= abort_set   | (abort    & ~(ctrl_wr & wdata[STAT_ABORT]));
            eoi_err  <= eoi_err_set | (eoi_err  & ~(ctrl_wr & wdata[STAT_EOI_ERR]));
            nest     <= nest_set    | (nest     & ~(ctrl_wr & wdata[STAT_NEST]));
        end
    end

    always_comb begin
        rdata = 8'h00;
        if (addr == CSR_ID) begin
            rdata = 8'(svc_id);
        end else begin
            rdata[STAT_ENABLE]     = enable;
            rdata[STAT_IN_SERVICE] = in_service;
            rdata[STAT_PENDING]    = irq_pending;
            rdata[STAT_SPURIOUS]   = spurious;
            rdata[STAT_ABORT]      = abort;
            rdata[STAT_EOI_ERR]    = eoi_err;
            rdata[STAT_NEST]       = nest;
        end
    end

endmodule
`default_nettype wire

// File: rtl/irq_vector_sequencer.sv
`default_nettype none
// ==========================================================================
// irq_vector_sequencer : substitutes per-source stub addresses for the 6502
//                        IRQ vector, tracks the in-service ID, issues EOI
// Revision             : 1.0
// ==========================================================================
module irq_vector_sequencer
    import irq_seq_pkg::*;
#(
    parameter int          ID_WIDTH  = 8,
    parameter logic [15:0] STUB_BASE = 16'hF000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         cpu_addr,
    input  logic                cpu_rwb,
    input  logic                cpu_valid,
    input  logic                irq_pending,
    input  logic [ID_WIDTH-1:0] irq_id,
    output logic                vec_override,
    output logic [7:0]          vec_data,
    output logic                o_eoi,
    input  logic                cs,
    input  logic                addr,
    input  logic                rwb,
    input  logic [7:0]          i_data,
    output logic [7:0]          o_data
);

    state_t              state;
    state_t              next_state;
    logic [ID_WIDTH-1:0] svc_id;
    logic                enable;
    logic                vfetch_lo;
    logic                vfetch_hi;
    logic                eoi_wr;
    logic [ID_WIDTH-1:0] tgt_id;
    logic [15:0]         target;
    logic                svc_load;
    logic                eoi_next;
    logic                spur_set;
    logic                abort_set;
    logic                eoi_err_set;
    logic                nest_set;

    assign vfetch_lo = cpu_valid & cpu_rwb & (cpu_addr == VEC_LO_ADDR);
    assign vfetch_hi = cpu_valid & cpu_rwb & (cpu_addr == VEC_HI_ADDR);
    assign eoi_wr    = cs & ~rwb & (addr == CSR_ID);

    // The low byte comes from the live ID, the high byte from the latched one.
    assign tgt_id = (state == ST_WAIT_HI) ? svc_id : irq_id;
    assign target = stub_target(STUB_BASE, 16'(tgt_id));

    always_ff @(negedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            svc_id <= '0;
            o_eoi  <= 1'b0;
        end else begin
            state <= next_state;
            o_eoi <= eoi_next;
            if (svc_load) begin
                svc_id <= irq_id;
            end
        end
    end

    always_comb begin
        next_state   = state;
        vec_override = 1'b0;
        vec_data     = 8'h00;
        svc_load     = 1'b0;
        eoi_next     = 1'b0;
        spur_set     = 1'b0;
        abort_set    = 1'b0;
        nest_set     = 1'b0;
        eoi_err_set  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (vfetch_lo && enable) begin
                    if (irq_pending) begin
                        vec_override = 1'b1;
                        vec_data     = target[7:0];
                        svc_load     = 1'b1;
                        next_state   = ST_WAIT_HI;
                    end else begin
                        spur_set = 1'b1;
                    end
                end
            end
            ST_WAIT_HI: begin
                if (vfetch_hi) begin
                    vec_override = 1'b1;
                    vec_data     = target[15:8];
                    next_state   = ST_IN_SERVICE;
                end else if (cpu_valid) begin
                    abort_set  = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            ST_IN_SERVICE: begin
                nest_set = vfetch_lo | vfetch_hi;
                if (eoi_wr) begin
                    eoi_next   = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
        if (eoi_wr && state != ST_IN_SERVICE) begin
            eoi_err_set = 1'b1;
        end
    end

    irq_seq_csr #(
        .ID_WIDTH (ID_WIDTH)
    ) u_csr (
        .clk         (clk),
        .reset       (reset),
        .cs          (cs),
        .addr        (addr),
        .rwb         (rwb),
        .wdata       (i_data),
        .spur_set    (spur_set),
        .abort_set   (abort_set),
        .eoi_err_set (eoi_err_set),
        .nest_set    (nest_set),
        .irq_pending (irq_pending),
        .in_service  (state == ST_IN_SERVICE),
        .svc_id      (svc_id),
        .enable      (enable),
        .rdata       (o_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_irq_vector_sequencer.sv
`default_nettype none
// Bench for irq_vector_sequencer: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_irq_vector_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic        cpu_rwb;
    logic        cpu_valid;
    logic        irq_pending;
    logic [7:0]  irq_id;
    logic        cs;
    logic        addr;
    logic        rwb;
    logic [7:0]  i_data;
    logic        vec_override, vec_override2;
    logic [7:0]  vec_data, vec_data2;
    logic        o_eoi, o_eoi2;
    logic [7:0]  o_data, o_data2;

    logic        s_ov, s_ov2, s_eoi, s_eoi2;
    logic [7:0]  s_vd, s_vd2, s_od, s_od2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    irq_vector_sequencer #(.ID_WIDTH(8), .STUB_BASE(16'hF000)) dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_rwb(cpu_rwb),
        .cpu_valid(cpu_valid), .irq_pending(irq_pending), .irq_id(irq_id),
        .vec_override(vec_override), .vec_data(vec_data), .o_eoi(o_eoi),
        .cs(cs), .addr(addr), .rwb(rwb), .i_data(i_data), .o_data(o_data)
    );

    irq_vector_sequencer #(.ID_WIDTH(8), .STUB_BASE(16'hFF00)) dut2 (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_rwb(cpu_rwb),
        .cpu_valid(cpu_valid), .irq_pending(irq_pending), .irq_id(irq_id),
        .vec_override(vec_override2), .vec_data(vec_data2), .o_eoi(o_eoi2),
        .cs(cs), .addr(addr), .rwb(rwb), .i_data(i_data), .o_data(o_data2)
    );

    // Outputs are captured on posedge, midway between the negedge state updates.
    task automatic step();
        @(posedge clk);
        s_ov = vec_override;  s_vd = vec_data;  s_eoi = o_eoi;  s_od = o_data;
        s_ov2 = vec_override2; s_vd2 = vec_data2; s_eoi2 = o_eoi2; s_od2 = o_data2;
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic r, input logic [15:0] a,
                         input logic c, input logic ca, input logic cr, input logic [7:0] d);
        cpu_valid = v; cpu_rwb = r; cpu_addr = a;
        cs = c; addr = ca; rwb = cr; i_data = d;
        step();
    endtask

    task automatic idle();                                drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h00); endtask
    task automatic bus_rd(input logic [15:0] a);          drive(1'b1, 1'b1, a, 1'b0, 1'b0, 1'b1, 8'h00); endtask
    task automatic bus_wr(input logic [15:0] a);          drive(1'b1, 1'b0, a, 1'b0, 1'b0, 1'b1, 8'h00); endtask
    task automatic csr_rd(input logic a);                 drive(1'b0, 1'b1, 16'h0000, 1'b1, a, 1'b1, 8'h00); endtask
    task automatic csr_wr(input logic a, input logic [7:0] d); drive(1'b0, 1'b1, 16'h0000, 1'b1, a, 1'b0, d); endtask

    task automatic test_reset();
        reset = 1'b1; irq_pending = 1'b0; irq_id = 8'h00;
        idle(); idle();
        reset = 1'b0;
        idle();
        n_checks++; if (s_ov !== 1'b0) begin n_fail++; $display("FAIL reset_override got %b want 0", s_ov); end
        n_checks++; if (s_vd !== 8'h00) begin n_fail++; $display("FAIL reset_vec_data got %h want 00", s_vd); end
        n_checks++; if (s_eoi !== 1'b0) begin n_fail++; $display("FAIL reset_eoi got %b want 0", s_eoi); end
        csr_rd(1'b0);
        n_checks++; if (s_od !== 8'h00) begin n_fail++; $display("FAIL reset_id got %h want 00", s_od); end
        csr_rd(1'b1);
        n_checks++; if (s_od !== 8'h00) begin n_fail++; $display("FAIL reset_status got %h want 00", s_od); end
    endtask

    task automatic test_vector_fetch();
        csr_wr(1'b1, 8'h01);
        irq_pending = 1'b1; irq_id = 8'h05;
        bus_rd(16'hFFFE);
        n_checks++; if (s_ov !== 1'b1 || s_vd !== 8'h14) begin n_fail++; $display("FAIL vec_lo got ov=%b data=%h want ov=1 data=14", s_ov, s_vd); end
        bus_rd(16'hFFFF);
        n_checks++; if (s_ov !== 1'b1 || s_vd !== 8'hF0) begin n_fail++; $display("FAIL vec_hi got ov=%b data=%h want ov=1 data=F0", s_ov, s_vd); end
        csr_rd(1'b0);
        n_checks++; if (s_od !== 8'h05) begin n_fail++; $display("FAIL svc_id got %h want 05", s_od); end
        csr_rd(1'b1);
        n_checks++; if (s_od !== 8'h07) begin n_fail++; $display("FAIL status_in_service got %h want 07", s_od); end
    endtask

    task automatic test_eoi();
        csr_wr(1'b0, 8'hA5);
        n_checks++; if (s_eoi !== 1'b0) begin n_fail++; $display("FAIL eoi_early got %b want 0", s_eoi); end
        idle();
        n_checks++; if (s_eoi !== 1'b1) begin n_fail++; $display("FAIL eoi_pulse got %b want 1", s_eoi); end
        csr_rd(1'b1);
        n_checks++; if (s_eoi !== 1'b0) begin n_fail++; $display("FAIL eoi_width got %b want 0", s_eoi); end
        n_checks++; if (s_od !== 8'h05) begin n_fail++; $display("FAIL status_after_eoi got %h want 05", s_od); end
        bus_rd(16'hFFFE);
        n_checks++; if (s_ov !== 1'b1) begin n_fail++; $display("FAIL idle_after_eoi got ov=%b want 1", s_ov); end
        bus_rd(16'hFFFF);
        csr_wr(1'b0, 8'h00);
        idle();
    endtask

    task automatic test_spurious();
        irq_pending = 1'b0;
        bus_rd(16'hFFFE);
        n_checks++; if (s_ov !== 1'b0) begin n_fail++; $display("FAIL spurious_override got %b want 0", s_ov); end
        csr_rd(1'b1);
        n_checks++; if (s_od !== 8'h09) begin n_fail++; $display("FAIL spurious_flag got %h want 09", s_od); end
        csr_wr(1'b1, 8'h09);
        csr_rd(1'b1);
        n_checks++; if (s_od !== 8'h01) begin n_fail++; $display("FAIL spurious_clear got %h want 01", s_od); end
    endtask

    task automatic test_wrap();
        irq_pending = 1'b1; irq_id = 8'hFF;
        bus_rd(16'hFFFE);
        n_checks++; if (s_ov !== 1'b1 || s_vd !== 8'hFC) begin n_fail++; $display("FAIL id_ff_lo got ov=%b data=%h want ov=1 data=FC", s_ov, s_vd); end
        bus_rd(16'hFFFF);
        n_checks++; if (s_vd !== 8'hF3) begin n_fail++; $display("FAIL id_ff_hi got %h want F3", s_vd); end
        n_checks++; if (s_vd2 !== 8'h02) begin n_fail++; $display("FAIL base_ff00_id_ff_hi got %h want 02", s_vd2); end
        csr_wr(1'b0, 8'h00);
        idle();
        n_checks++; if (s_eoi2 !== 1'b1) begin n_fail++; $display("FAIL base_ff00_eoi got %b want 1", s_eoi2); end
        irq_id = 8'h40;
        bus_rd(16'hFFFE);
        n_checks++; if (s_ov2 !== 1'b1 || s_vd2 !== 8'h00) begin n_fail++; $display("FAIL wrap_lo got ov=%b data=%h want ov=1 data=00", s_ov2, s_vd2); end
        n_checks++; if (s_vd !== 8'h00) begin n_fail++; $display("FAIL id_40_lo got %h want 00", s_vd); end
        bus_rd(16'hFFFF);
        n_checks++; if (s_ov2 !== 1'b1 || s_vd2 !== 8'h00) begin n_fail++; $display("FAIL wrap_hi got ov=%b data=%h want ov=1 data=00", s_ov2, s_vd2); end
        n_checks++; if (s_vd !== 8'hF1) begin n_fail++; $display("FAIL id_40_hi got %h want F1", s_vd); end
        csr_rd(1'b0);
        n_checks++; if (s_od2 !== 8'h40) begin n_fail++; $display("FAIL wrap_svc_id got %h want 40", s_od2); end
        csr_wr(1'b0, 8'h00);
        idle();
    endtask

    task automatic test_abort();
        csr_wr(1'b1, 8'h79);
        irq_pending = 1'b1; irq_id = 8'h11;
        bus_rd(16'hFFFE);
        n_checks++; if (s_ov !== 1'b1) begin n_fail++; $display("FAIL abort_lo got %b want 1", s_ov); end
        bus_wr(16'h0200);
        n_checks++; if (s_ov !== 1'b0) begin n_fail++; $display("FAIL abort_cycle got %b want 0", s_ov); end
        bus_rd(16'hFFFF);
        n_checks++; if (s_ov !== 1'b0) begin n_fail++; $display("FAIL abort_hi got %b want 0", s_ov); end
        csr_rd(1'b1);
        n_checks++; if (s_od !== 8'h15) begin n_fail++; $display("FAIL abort_flag got %h want 15", s_od); end
        csr_wr(1'b1, 8'h79);
    endtask

    task automatic test_eoi_err_nest();
        csr_wr(1'b0, 8'h00);
        idle();
        n_checks++; if (s_eoi !== 1'b0) begin n_fail++; $display("FAIL stray_eoi got %b want 0", s_eoi); end
        csr_rd(1'b1);
        n_checks++; if (s_od !== 8'h25) begin n_fail++; $display("FAIL eoi_err_flag got %h want 25", s_od); end
        csr_wr(1'b1, 8'h79);
        bus_rd(16'hFFFE);
        // Clearing enable mid-sequence must not stop the high byte override.
        csr_wr(1'b1, 8'h00);
        bus_rd(16'hFFFF);
        n_checks++; if (s_ov !== 1'b1) begin n_fail++; $display("FAIL enable_cleared_hi got %b want 1", s_ov); end
        bus_rd(16'hFFFE);
        n_checks++; if (s_ov !== 1'b0) begin n_fail++; $display("FAIL nest_override got %b want 0", s_ov); end
        csr_rd(1'b1);
        n_checks++; if (s_od !== 8'h46) begin n_fail++; $display("FAIL nest_flag got %h want 46", s_od); end
        csr_wr(1'b0, 8'h00);
        csr_wr(1'b1, 8'h79);
    endtask

    task automatic test_reset_mid();
        irq_pending = 1'b1; irq_id = 8'h22;
        bus_rd(16'hFFFE);
        n_checks++; if (s_ov !== 1'b1) begin n_fail++; $display("FAIL mid_lo got %b want 1", s_ov); end
        reset = 1'b1; irq_pending = 1'b0;
        idle();
        reset = 1'b0;
        bus_rd(16'hFFFF);
        n_checks++; if (s_ov !== 1'b0) begin n_fail++; $display("FAIL mid_reset_override got %b want 0", s_ov); end
        n_checks++; if (s_eoi !== 1'b0) begin n_fail++; $display("FAIL mid_reset_eoi got %b want 0", s_eoi); end
        csr_rd(1'b1);
        n_checks++; if (s_od !== 8'h00) begin n_fail++; $display("FAIL mid_reset_status got %h want 00", s_od); end
    endtask

    // Transaction-level model: each bus cycle is classified and applied to a
    // handful of booleans describing where the CPU is in its interrupt entry.
    task automatic test_random();
        bit          m_en = 0, m_waiting = 0, m_serving = 0, m_eoi_due = 0;
        bit          m_spur = 0, m_abort = 0, m_eoierr = 0, m_nest = 0;
        logic [7:0]  m_svc = 8'h00;
        reset = 1'b1; idle(); reset = 1'b0;
        for (int i = 0; i < 400; i++) begin
            int          op;
            logic [7:0]  d;
            logic [15:0] a;
            bit          exp_ov;
            logic [7:0]  exp_vd, exp_od;
            bit          is_read;
            int          tgt;
            op          = $urandom_range(0, 9);
            irq_pending = ($urandom_range(0, 3) != 0);
            irq_id      = 8'($urandom);
            exp_ov = 0; exp_vd = 8'h00; exp_od = 8'h00; is_read = 0;
            case (op)
                0, 1: begin
                    bus_rd(16'hFFFE);
                    if (m_waiting) begin m_abort = 1; m_waiting = 0; end
                    else if (m_serving) m_nest = 1;
                    else if (m_en && irq_pending) begin
                        tgt = (16'hF000 + 4 * int'(irq_id)) % 65536;
                        exp_ov = 1; exp_vd = 8'(tgt % 256);
                        m_svc = irq_id; m_waiting = 1;
                    end else if (m_en) m_spur = 1;
                end
                2, 3: begin
                    bus_rd(16'hFFFF);
                    if (m_waiting) begin
                        tgt = (16'hF000 + 4 * int'(m_svc)) % 65536;
                        exp_ov = 1; exp_vd = 8'(tgt / 256);
                        m_waiting = 0; m_serving = 1;
                    end else if (m_serving) m_nest = 1;
                end
                4: begin
                    a = 16'($urandom_range(0, 16'hFFFD));
                    if ($urandom_range(0, 1) == 0) bus_rd(a); else bus_wr(a);
                    if (m_waiting) begin m_abort = 1; m_waiting = 0; end
                end
                5: begin
                    csr_rd(1'b0);
                    is_read = 1; exp_od = m_svc;
                end
                6: begin
                    csr_rd(1'b1);
                    is_read = 1;
                    exp_od = {1'b0, m_nest, m_eoierr, m_abort, m_spur, irq_pending, m_serving, m_en};
                end
                7: begin
                    csr_wr(1'b0, 8'($urandom));
                end
                8: begin
                    d = 8'($urandom);
                    d[0] = ($urandom_range(0, 4) != 0);
                    csr_wr(1'b1, d);
                    m_en = d[0];
                    if (d[3]) m_spur = 0;
                    if (d[4]) m_abort = 0;
                    if (d[5]) m_eoierr = 0;
                    if (d[6]) m_nest = 0;
                end
                default: idle();
            endcase
            n_checks++; if (s_ov !== exp_ov) begin n_fail++; $display("FAIL rnd_override it=%0d op=%0d got %b want %b", i, op, s_ov, exp_ov); end
            if (exp_ov) begin
                n_checks++; if (s_vd !== exp_vd) begin n_fail++; $display("FAIL rnd_vec_data it=%0d got %h want %h", i, s_vd, exp_vd); end
            end
            n_checks++; if (s_eoi !== m_eoi_due) begin n_fail++; $display("FAIL rnd_eoi it=%0d got %b want %b", i, s_eoi, m_eoi_due); end
            if (is_read) begin
                n_checks++; if (s_od !== exp_od) begin n_fail++; $display("FAIL rnd_csr_read it=%0d op=%0d got %h want %h", i, op, s_od, exp_od); end
            end
            m_eoi_due = 0;
            if (op == 7) begin
                if (m_serving) begin m_eoi_due = 1; m_serving = 0; end
                else m_eoierr = 1;
            end
        end
    endtask

    initial begin
        reset = 1'b1; cpu_addr = 16'h0000; cpu_rwb = 1'b1; cpu_valid = 1'b0;
        irq_pending = 1'b0; irq_id = 8'h00; cs = 1'b0; addr = 1'b0; rwb = 1'b1; i_data = 8'h00;
        test_reset();
        test_vector_fetch();
        test_eoi();
        test_spurious();
        test_wrap();
        test_abort();
        test_eoi_err_nest();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
